mem_wb_stage: RTL and testbench

- MEM/WB pipeline stage of the 8-bit five-stage CPU (IF ID EXE MEM WB). Sits directly downstream of the data memory.
- Latches EXE/MEM control and ALU result on the same edge on which the data memory registers its read data, so both are aligned in the WB cycle.
- Selects the write-back value, drives the register-file write port and the forwarding bus, and keeps a retired-instruction counter.
- Handles stall (including preserving load data across stalls) and flush.

---
 rtl/mem_wb_stage.sv | 114 +++++++++++
 tb/tb_mem_wb_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: latches EXE/MEM control, selects write-back data, drives RF write port, forwarding bus and retire counter.
// Latency: instruction on ex_* at edge k appears on rf_*/fwd_* during cycle k..k+1; load data is used in that same cycle.
// Backpressure: stall holds all wb state and captures load data once; flush squashes the WB slot (flush wins over stall).
module mem_wb_stage #(
  parameter int DATA_W      = 8,
  parameter int REG_ADDR_W  = 3,
  parameter int CNT_W       = 16,
  parameter bit ZERO_REG_EN = 1'b1
) (
  input  logic                  sysclk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic [DATA_W-1:0]     mem_read_data,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      retire_count
);

  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic                  wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]     wb_alu_q, wb_alu_d;
  logic [DATA_W-1:0]     hold_data_q, hold_data_d;
  logic                  hold_vld_q, hold_vld_d;
  logic [CNT_W-1:0]      retire_q, retire_d;
  logic [DATA_W-1:0]     wb_data;
  logic                  rd_is_zero;

  // Next-state selection with priority flush > stall > advance.
  always_comb begin
    wb_valid_d      = wb_valid_q;
    wb_reg_write_d  = wb_reg_write_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_rd_d         = wb_rd_q;
    wb_alu_d        = wb_alu_q;
    hold_data_d     = hold_data_q;
    hold_vld_d      = hold_vld_q;
    retire_d        = retire_q;
    if (flush) begin
      // Squashed instruction is dropped without being counted.
      wb_valid_d = 1'b0;
      hold_vld_d = 1'b0;
    end else if (stall) begin
      // Memory output is only valid on the first stalled edge, so sample it once.
      if (wb_valid_q && wb_mem_to_reg_q && !hold_vld_q) begin
        hold_data_d = mem_read_data;
        hold_vld_d  = 1'b1;
      end
    end else begin
      wb_valid_d      = ex_valid;
      wb_reg_write_d  = ex_reg_write;
      wb_mem_to_reg_d = ex_mem_to_reg;
      wb_rd_d         = ex_rd;
      wb_alu_d        = ex_alu_result;
      hold_vld_d      = 1'b0;
      if (wb_valid_q) begin
        retire_d = retire_q + 1'b1;
      end
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q      <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_q         <= '0;
      wb_alu_q        <= '0;
      hold_data_q     <= '0;
      hold_vld_q      <= 1'b0;
      retire_q        <= '0;
    end else begin
      wb_valid_q      <= wb_valid_d;
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_rd_q         <= wb_rd_d;
      wb_alu_q        <= wb_alu_d;
      hold_data_q     <= hold_data_d;
      hold_vld_q      <= hold_vld_d;
      retire_q        <= retire_d;
    end
  end

  // Write-back mux and register-file / forwarding outputs.
  always_comb begin
    rd_is_zero = (wb_rd_q == '0);
    if (wb_mem_to_reg_q) begin
      wb_data = hold_vld_q ? hold_data_q : mem_read_data;
    end else begin
      wb_data = wb_alu_q;
    end
    rf_we     = wb_valid_q & wb_reg_write_q & ~(ZERO_REG_EN & rd_is_zero);
    rf_waddr  = wb_rd_q;
    rf_wdata  = wb_data;
    fwd_valid = rf_we;
    fwd_rd    = wb_rd_q;
    fwd_data  = wb_data;
  end

  assign retire_count = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
  logic        sysclk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [7:0]  ex_alu_result;
  logic [2:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic [7:0]  mem_read_data;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [7:0]  rf_wdata;
  logic        fwd_valid;
  logic [2:0]  fwd_rd;
  logic [7:0]  fwd_data;
  logic [15:0] retire_count;

  int n_tests;
  int n_fail;

  mem_wb_stage #(
    .DATA_W(8), .REG_ADDR_W(3), .CNT_W(16), .ZERO_REG_EN(1'b1)
  ) dut (
    .sysclk(sysclk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_read_data(mem_read_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] alu, input logic [2:0] rd,
                       input logic rw, input logic m2r);
    ex_valid      = v;
    ex_alu_result = alu;
    ex_rd         = rd;
    ex_reg_write  = rw;
    ex_mem_to_reg = m2r;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},    32'(rf_we),        32'h0);
    chk({tag, "_waddr"}, 32'(rf_waddr),     32'h0);
    chk({tag, "_wdata"}, 32'(rf_wdata),     32'h0);
    chk({tag, "_fv"},    32'(fwd_valid),    32'h0);
    chk({tag, "_frd"},   32'(fwd_rd),       32'h0);
    chk({tag, "_fdat"},  32'(fwd_data),     32'h0);
    chk({tag, "_cnt"},   32'(retire_count), 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; mem_read_data = 8'h00;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #12;
    chk_all_zero("reset");
    @(negedge sysclk);
    rst_n = 1'b1;

    // 1: ALU op to r5
    drive(1'b1, 8'h3C, 3'd5, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    chk("alu_we",    32'(rf_we),     32'h1);
    chk("alu_waddr", 32'(rf_waddr),  32'h5);
    chk("alu_wdata", 32'(rf_wdata),  32'h3C);
    chk("alu_fv",    32'(fwd_valid), 32'h1);
    chk("alu_frd",   32'(fwd_rd),    32'h5);
    chk("alu_fdat",  32'(fwd_data),  32'h3C);
    chk("alu_cnt0",  32'(retire_count), 32'h0);
    tick();
    chk("alu_cnt1",  32'(retire_count), 32'h1);

    // 2: load, no stall
    drive(1'b1, 8'h40, 3'd2, 1'b1, 1'b1);
    tick();
    mem_read_data = 8'hA5;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    chk("ld_we",    32'(rf_we),    32'h1);
    chk("ld_waddr", 32'(rf_waddr), 32'h2);
    chk("ld_wdata", 32'(rf_wdata), 32'hA5);
    chk("ld_fdat",  32'(fwd_data), 32'hA5);
    tick();
    chk("ld_cnt", 32'(retire_count), 32'h2);

    // 3: load with 3-cycle stall; next instruction waits on ex_*
    drive(1'b1, 8'h41, 3'd3, 1'b1, 1'b1);
    tick();
    mem_read_data = 8'hA5;
    stall = 1'b1;
    drive(1'b1, 8'h99, 3'd6, 1'b1, 1'b0);
    #1;
    chk("st_wdata0", 32'(rf_wdata), 32'hA5);
    tick();
    mem_read_data = 8'h11;
    #1;
    chk("st_wdata1", 32'(rf_wdata), 32'hA5);
    chk("st_we1",    32'(rf_we),    32'h1);
    chk("st_waddr1", 32'(rf_waddr), 32'h3);
    chk("st_cnt1",   32'(retire_count), 32'h2);
    tick();
    mem_read_data = 8'h22;
    #1;
    chk("st_wdata2", 32'(rf_wdata), 32'hA5);
    chk("st_cnt2",   32'(retire_count), 32'h2);
    tick();
    stall = 1'b0;
    #1;
    chk("st_wdata3", 32'(rf_wdata), 32'hA5);
    chk("st_cnt3",   32'(retire_count), 32'h2);
    tick();
    chk("st_cnt4",   32'(retire_count), 32'h3);
    chk("st_next_wdata", 32'(rf_wdata), 32'h99);
    chk("st_next_waddr", 32'(rf_waddr), 32'h6);

    // 4: write to r0 is suppressed but counted
    drive(1'b1, 8'h7F, 3'd0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    chk("r0_we",    32'(rf_we),    32'h0);
    chk("r0_fv",    32'(fwd_valid), 32'h0);
    chk("r0_wdata", 32'(rf_wdata), 32'h7F);
    chk("r0_cnt0",  32'(retire_count), 32'h4);
    tick();
    chk("r0_cnt1",  32'(retire_count), 32'h5);

    // 5: flush together with stall while a load is in WB
    drive(1'b1, 8'h42, 3'd4, 1'b1, 1'b1);
    tick();
    mem_read_data = 8'h5A;
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    chk("fl_we_pre", 32'(rf_we), 32'h1);
    tick();
    stall = 1'b0;
    flush = 1'b0;
    #1;
    chk("fl_we",  32'(rf_we), 32'h0);
    chk("fl_cnt", 32'(retire_count), 32'h5);
    // a new load must take live memory data, proving hold was cleared
    drive(1'b1, 8'h43, 3'd1, 1'b1, 1'b1);
    tick();
    mem_read_data = 8'h33;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    chk("fl_ld_wdata", 32'(rf_wdata), 32'h33);
    chk("fl_ld_cnt",   32'(retire_count), 32'h5);
    tick();
    chk("fl_ld_cnt1",  32'(retire_count), 32'h6);

    // 6: async reset, then counter wrap
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst2");
    @(negedge sysclk);
    rst_n = 1'b1;
    drive(1'b1, 8'h55, 3'd7, 1'b1, 1'b0);
    repeat (65536) tick();
    chk("wrap_max", 32'(retire_count), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(retire_count), 32'h0);
    chk("wrap_we",   32'(rf_we), 32'h1);
    // reset mid-cycle while stalled on a load with captured data
    drive(1'b1, 8'h44, 3'd2, 1'b1, 1'b1);
    tick();
    mem_read_data = 8'hC3;
    stall = 1'b1;
    tick();
    chk("rs_cnt", 32'(retire_count), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst3");
    stall = 1'b0;
    @(negedge sysclk);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
